mm_seq_ctrl: RTL and testbench

Sequencing controller for the matrix-multiply memory bank and MAC array. It accepts a start command and the W/X matrix dimensions (each 1..3). It then clears the bank and gates host data beats into the W and X stores with a valid/ready handshake. It streams the inner-dimension steps to the MAC array, waits out the MAC pipeline, and signals completion. It sits between the host-side data port and the memory bank / MAC datapath, and it replaces free-running load/unload counters with one explicit FSM.

---
 rtl/mm_pkg.sv | 23 ++
 rtl/mm_step_cnt.sv | 31 +++
 rtl/mm_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_mm_seq_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply sequencing controller.
package mm_pkg;

  localparam int DIM_MAX    = 3;
  localparam int ELEM_W     = 4;
  localparam int ADDR_W_DEF = $clog2(DIM_MAX * DIM_MAX);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    LOAD_W = 3'd2,
    LOAD_X = 3'd3,
    STREAM = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  // Element count of a matrix: 2b x 2b product, zero-extended.
  function automatic logic [ELEM_W-1:0] elem_count(input logic [1:0] rows, input logic [1:0] cols);
    return {2'b00, rows} * {2'b00, cols};
  endfunction

endpackage

// File: rtl/mm_step_cnt.sv
// Loadable up-counter with enable, terminal-count compare and synchronous clear.
module mm_step_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic [W-1:0] tc,
  output logic [W-1:0] count,
  output logic         last
);

  assign last = (count == tc);

  // Count register; wraps to zero when stepping past the terminal count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= last ? '0 : count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/mm_seq_ctrl.sv
// Sequencing FSM for the matrix-multiply bank and MAC array.
// Optional build macro: MM_DIM_CHECK_EN also rejects starts with col_w != row_x.
module mm_seq_ctrl
  import mm_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DRAIN_CYC = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        row_w,
  input  logic [1:0]        col_w,
  input  logic [1:0]        row_x,
  input  logic [1:0]        col_x,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              clear_mem,
  output logic              rd_en,
  output logic [1:0]        rd_k,
  output logic              ld_mac,
  output logic              clear_mac,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  state_t              state, state_nxt;
  logic [1:0]          row_w_r, col_w_r, row_x_r, col_x_r;
  logic [ELEM_W-1:0]   n_w, n_x, ld_cnt, ld_tc;
  logic [1:0]          st_cnt, st_tc;
  logic [DRAIN_W-1:0]  dr_cnt, dr_tc;
  logic                ld_last, st_last, dr_last;
  logic                beat, reject, accept, cnt_clr;

`ifdef MM_DIM_CHECK_EN
  assign reject = (row_w == 2'd0) || (col_w == 2'd0) || (row_x == 2'd0) || (col_x == 2'd0)
                  || (col_w != row_x);
`else
  assign reject = (row_w == 2'd0) || (col_w == 2'd0) || (row_x == 2'd0) || (col_x == 2'd0);
`endif

  assign accept  = (state == IDLE) && start && !reject;
  // A beat arriving while reset is asserted is not written.
  assign beat    = in_valid && in_ready && !rst;
  assign mem_we  = beat;
  assign n_w     = elem_count(row_w_r, col_w_r);
  assign n_x     = elem_count(row_x_r, col_x_r);
  assign ld_tc   = (state == LOAD_X) ? (n_x - 4'd1) : (n_w - 4'd1);
  assign st_tc   = col_w_r - 2'd1;
  assign dr_tc   = DRAIN_W'(DRAIN_CYC - 1);
  assign cnt_clr = (state == CLR);
  assign mem_addr = ADDR_W'(ld_cnt);
  assign rd_k     = st_cnt;

  mm_step_cnt #(.W(ELEM_W)) u_ld_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .load(1'b0), .load_val({ELEM_W{1'b0}}),
    .en(beat), .tc(ld_tc), .count(ld_cnt), .last(ld_last)
  );

  mm_step_cnt #(.W(2)) u_st_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .load(1'b0), .load_val(2'b00),
    .en(state == STREAM), .tc(st_tc), .count(st_cnt), .last(st_last)
  );

  mm_step_cnt #(.W(DRAIN_W)) u_dr_cnt (
    .clk(clk), .rst(rst), .clr(cnt_clr), .load(1'b0), .load_val({DRAIN_W{1'b0}}),
    .en(state == DRAIN), .tc(dr_tc), .count(dr_cnt), .last(dr_last)
  );

  // Dimension latch, captured only on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_w_r <= 2'd0;
      col_w_r <= 2'd0;
      row_x_r <= 2'd0;
      col_x_r <= 2'd0;
    end else if (accept) begin
      row_w_r <= row_w;
      col_w_r <= col_w;
      row_x_r <= row_x;
      col_x_r <= col_x;
    end else begin
      row_w_r <= row_w_r;
      col_w_r <= col_w_r;
      row_x_r <= row_x_r;
      col_x_r <= col_x_r;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? CLR : IDLE;
      CLR:     state_nxt = LOAD_W;
      LOAD_W:  state_nxt = (beat && ld_last) ? LOAD_X : LOAD_W;
      LOAD_X:  state_nxt = (beat && ld_last) ? STREAM : LOAD_X;
      STREAM:  state_nxt = st_last ? DRAIN : STREAM;
      DRAIN:   state_nxt = dr_last ? DONE : DRAIN;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with outputs registered from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      mem_sel   <= 1'b0;
      clear_mem <= 1'b0;
      clear_mac <= 1'b0;
      rd_en     <= 1'b0;
      ld_mac    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == LOAD_W) || (state_nxt == LOAD_X);
      mem_sel   <= (state_nxt == LOAD_X);
      clear_mem <= (state_nxt == CLR);
      clear_mac <= (state_nxt == CLR);
      rd_en     <= (state_nxt == STREAM);
      ld_mac    <= (state_nxt == STREAM);
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      err       <= (state == IDLE) && start && reject;
    end
  end

endmodule

// File: tb/tb_mm_seq_ctrl.sv
// Directed, table-driven bench for mm_seq_ctrl; honours MM_DIM_CHECK_EN when defined.
module tb_mm_seq_ctrl;

  logic       clk, rst, start, in_valid;
  logic [1:0] row_w, col_w, row_x, col_x;
  logic       in_ready, mem_we, mem_sel, clear_mem, rd_en, ld_mac, clear_mac, busy, done, err;
  logic [3:0] mem_addr;
  logic [1:0] rd_k;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        iv;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[26];

  mm_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .row_w(row_w), .col_w(col_w), .row_x(row_x), .col_x(col_x),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .clear_mem(clear_mem), .rd_en(rd_en), .rd_k(rd_k),
    .ld_mac(ld_mac), .clear_mac(clear_mac), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pack: {busy,in_ready,mem_we,mem_sel,addr,rd_en,ld_mac,rd_k,done,clear_mem,clear_mac,err}
  function automatic logic [15:0] ep(int b, int r, int w, int s, int a, int rd, int k, int d, int cl);
    return {b[0], r[0], w[0], s[0], a[3:0], rd[0], rd[0], k[1:0], d[0], cl[0], cl[0], 1'b0};
  endfunction

  function automatic logic [15:0] act_full();
    return {busy, in_ready, mem_we, mem_sel, mem_addr, rd_en, ld_mac, rd_k, done, clear_mem, clear_mac, err};
  endfunction

  function automatic logic [15:0] act_masked();
    return {busy, in_ready, mem_we, mem_sel, mem_we ? mem_addr : 4'd0, rd_en, ld_mac,
            rd_en ? rd_k : 2'd0, done, clear_mem, clear_mac, err};
  endfunction

  initial begin
    // 2x3 . 3x1 with in_valid high only on even cycles; entry i is cycle i+1.
    tbl[0]  = '{1'b0, ep(1,0,0,0,0,0,0,0,1)};
    tbl[1]  = '{1'b1, ep(1,1,1,0,0,0,0,0,0)};
    tbl[2]  = '{1'b0, ep(1,1,0,0,1,0,0,0,0)};
    tbl[3]  = '{1'b1, ep(1,1,1,0,1,0,0,0,0)};
    tbl[4]  = '{1'b0, ep(1,1,0,0,2,0,0,0,0)};
    tbl[5]  = '{1'b1, ep(1,1,1,0,2,0,0,0,0)};
    tbl[6]  = '{1'b0, ep(1,1,0,0,3,0,0,0,0)};
    tbl[7]  = '{1'b1, ep(1,1,1,0,3,0,0,0,0)};
    tbl[8]  = '{1'b0, ep(1,1,0,0,4,0,0,0,0)};
    tbl[9]  = '{1'b1, ep(1,1,1,0,4,0,0,0,0)};
    tbl[10] = '{1'b0, ep(1,1,0,0,5,0,0,0,0)};
    tbl[11] = '{1'b1, ep(1,1,1,0,5,0,0,0,0)};
    tbl[12] = '{1'b0, ep(1,1,0,1,0,0,0,0,0)};
    tbl[13] = '{1'b1, ep(1,1,1,1,0,0,0,0,0)};
    tbl[14] = '{1'b0, ep(1,1,0,1,1,0,0,0,0)};
    tbl[15] = '{1'b1, ep(1,1,1,1,1,0,0,0,0)};
    tbl[16] = '{1'b0, ep(1,1,0,1,2,0,0,0,0)};
    tbl[17] = '{1'b1, ep(1,1,1,1,2,0,0,0,0)};
    tbl[18] = '{1'b0, ep(1,0,0,0,0,1,0,0,0)};
    tbl[19] = '{1'b1, ep(1,0,0,0,0,1,1,0,0)};
    tbl[20] = '{1'b0, ep(1,0,0,0,0,1,2,0,0)};
    tbl[21] = '{1'b1, ep(1,0,0,0,0,0,0,0,0)};
    tbl[22] = '{1'b0, ep(1,0,0,0,0,0,0,0,0)};
    tbl[23] = '{1'b1, ep(1,0,0,0,0,0,0,0,0)};
    tbl[24] = '{1'b0, ep(1,0,0,0,0,0,0,1,0)};
    tbl[25] = '{1'b1, ep(0,0,0,0,0,0,0,0,0)};

    clk = 1'b0; rst = 1'b1; start = 1'b0; in_valid = 1'b0;
    row_w = 2'd1; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;

    step(); step();
    chk("reset_outputs", act_full(), 16'h0000);
    rst = 1'b0;
    step();
    chk("idle_outputs", act_full(), 16'h0000);

    // Full 3x3 . 3x3 with in_valid held high.
    row_w = 2'd3; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3;
    start = 1'b1; in_valid = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      int a;
      a = (c >= 2 && c <= 10) ? c - 2 : ((c >= 11 && c <= 19) ? c - 11 : 0);
      chk($sformatf("full3x3_c%0d", c), act_masked(),
          ep(c <= 26, c >= 2 && c <= 19, c >= 2 && c <= 19, c >= 11 && c <= 19, a,
             c >= 20 && c <= 22, (c >= 20 && c <= 22) ? c - 20 : 0, c == 26, c == 1));
      step();
    end

    // 2x3 . 3x1 with toggling in_valid, from the table.
    row_w = 2'd2; col_w = 2'd3; row_x = 2'd3; col_x = 2'd1;
    in_valid = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      in_valid = tbl[i].iv;
      #1;
      chk($sformatf("toggle_c%0d", i + 1), act_full(), tbl[i].exp);
      step();
    end

    // Zero dimension rejected.
    in_valid = 1'b0;
    row_w = 2'd0; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("zero_dim_err", {err, busy, clear_mem}, {1'b1, 1'b0, 1'b0});
    step();
    chk("zero_dim_after", {err, busy, clear_mem}, {1'b0, 1'b0, 1'b0});

    // Inner-dimension mismatch: col_w=2, row_x=3.
    row_w = 2'd1; col_w = 2'd2; row_x = 2'd3; col_x = 2'd1;
    in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
`ifdef MM_DIM_CHECK_EN
    chk("mismatch_err", {err, busy, clear_mem}, {1'b1, 1'b0, 1'b0});
    step();
    chk("mismatch_after", {err, busy}, {1'b0, 1'b0});
`else
    for (int c = 1; c <= 13; c++) begin
      int a;
      a = (c >= 2 && c <= 3) ? c - 2 : ((c >= 4 && c <= 6) ? c - 4 : 0);
      chk($sformatf("mismatch_c%0d", c), act_masked(),
          ep(c <= 12, c >= 2 && c <= 6, c >= 2 && c <= 6, c >= 4 && c <= 6, a,
             c >= 7 && c <= 8, (c >= 7 && c <= 8) ? c - 7 : 0, c == 12, c == 1));
      step();
    end
`endif

    // Reset on the 4th LOAD_X beat, then a fresh run.
    row_w = 2'd3; col_w = 2'd3; row_x = 2'd3; col_x = 2'd3;
    in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 14; c++) step();
    chk("pre_rst_state", {in_ready, mem_sel, mem_addr}, {1'b1, 1'b1, 4'd3});
    rst = 1'b1;
    #1;
    chk("rst_no_we", {31'd0, mem_we}, 32'd0);
    step();
    rst = 1'b0;
    chk("rst_idle", {busy, in_ready, mem_we, done}, 4'b0000);
    begin
      int dn;
      dn = 0;
      for (int c = 0; c < 30; c++) begin
        if (done === 1'b1) dn++;
        step();
      end
      chk("rst_no_done", dn, 0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    begin
      int c;
      c = 1;
      while (done !== 1'b1 && c < 40) begin
        step();
        c++;
      end
      chk("rerun_done_cycle", c, 26);
    end
    step();

    // start held high: 1x1 . 1x1 runs back to back, period 9 cycles.
    row_w = 2'd1; col_w = 2'd1; row_x = 2'd1; col_x = 2'd1;
    in_valid = 1'b1; start = 1'b1;
    step();
    begin
      logic [19:0] clrv;
      int dn;
      logic busy9;
      clrv = 20'd0; dn = 0; busy9 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
        clrv[c-1] = clear_mem;
        if (done === 1'b1) dn++;
        if (c == 9) busy9 = busy;
        step();
      end
      start = 1'b0;
      chk("b2b_clear_pattern", clrv, 20'h40201);
      chk("b2b_done_count", dn, 2);
      chk("b2b_idle_gap", {31'd0, busy9}, 32'd0);
    end
    begin
      int c;
      c = 0;
      while (busy !== 1'b0 && c < 30) begin
        step();
        c++;
      end
      chk("b2b_final_idle", {31'd0, busy}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
